// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader state enum and the bytes-per-word constant.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs 4 little-endian bytes into a 32-bit word.
// Ports: clk, rst, clear, byte_valid, byte_data in;
//        word_fire (comb, 4th byte now), word_valid/word (registered).
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_fire,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] part;

  assign word_fire = byte_valid &&
    (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      part <= '0;
    end else if (byte_valid) begin
      cnt  <= cnt + 2'd1;
      part <= {byte_data, part[23:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= word_fire;
      if (word_fire)
        word <= {byte_data, part};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader into instruction memory; holds CPU in reset.
// Ports: clk, rst, start, in_valid/in_data/in_ready stream,
//        mem_we/mem_addr/mem_wdata write port, cpu_hold, done, err.
// Option: IMEM_LOADER_CSUM_EN adds a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DEPTH         = 256,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     err
);

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_t TAIL = S_CSUM;
`else
  localparam state_t TAIL = S_DONE;
`endif

  state_t      state;
  state_t      state_n;
  logic [15:0] len_q;
  logic [15:0] index;
  logic [15:0] n_in;
  logic        xfer;
  logic        clear;
  logic        last_word;
  logic        word_fire;
  logic        word_valid;
  logic [31:0] word;

  assign xfer  = in_valid && in_ready;
  assign clear = start && (state == S_IDLE ||
                 state == S_DONE || state == S_ERROR);
  assign n_in  = {in_data, len_q[7:0]};
  assign last_word = (index == len_q - 16'd1);

  imem_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .byte_valid (xfer && state == S_DATA),
    .byte_data  (in_data),
    .word_fire  (word_fire),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (rst || clear)
      csum <= '0;
    else if (xfer && state == S_DATA)
      csum <= csum ^ in_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (start) state_n = S_LEN_LO;
      S_LEN_LO:
        if (xfer) state_n = S_LEN_HI;
      S_LEN_HI:
        if (xfer) begin
          if (32'(n_in) > DEPTH)
            state_n = S_ERROR;
          else if (n_in == 16'd0)
            state_n = TAIL;
          else
            state_n = S_DATA;
        end
      S_DATA:
        if (word_fire && last_word)
          state_n = TAIL;
      S_CSUM: begin
`ifdef IMEM_LOADER_CSUM_EN
        if (xfer)
          state_n = (in_data == csum) ?
                    S_DONE : S_ERROR;
`else
        state_n = S_IDLE;
`endif
      end
      default:
        state_n = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      S_DONE:  done = 1'b1;
      S_ERROR: err  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      index    <= '0;
      mem_addr <= BASE_ADDR;
    end else if (clear) begin
      len_q <= '0;
      index <= '0;
    end else begin
      if (xfer && state == S_LEN_LO)
        len_q[7:0] <= in_data;
      if (xfer && state == S_LEN_HI)
        len_q[15:8] <= in_data;
      if (word_fire) begin
        mem_addr <= BASE_ADDR +
          ADDRESS_WIDTH'({index, 2'b00});
        index <= index + 16'd1;
      end
    end
  end

  assign mem_we    = word_valid;
  assign mem_wdata = DATA_WIDTH'(word);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed + random frames
// against a byte-position model of the frame format.
module tb_imem_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0;
`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  imem_loader #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (32),
    .DEPTH         (DEPTH),
    .BASE_ADDR     (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  bit          m_busy, m_done, m_err, m_we;
  logic [31:0] m_addr, m_wdata, m_word;
  logic [7:0]  m_lo, m_x;
  int          m_pos, m_len;

  logic [31:0] log_a[$];
  logic [31:0] log_d[$];

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, a, e, $time);
    end
  endtask

  // Frame model: outcome follows from byte position in the frame.
  task automatic model_update();
    int d;
    m_we = 1'b0;
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_pos = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_done = 0; m_err = 0;
        m_pos = 0; m_x = 0; m_word = 0;
      end
    end else if (in_valid) begin
      if (m_pos == 0) begin
        m_lo = in_data;
      end else if (m_pos == 1) begin
        m_len = int'({in_data, m_lo});
        if (m_len > DEPTH) begin
          m_busy = 0; m_err = 1;
        end else if (m_len == 0 && !CSUM) begin
          m_busy = 0; m_done = 1;
        end
      end else if (m_pos - 2 < 4 * m_len) begin
        d = m_pos - 2;
        m_x = m_x ^ in_data;
        m_word = m_word |
          (32'(in_data) << (8 * (d % 4)));
        if (d % 4 == 3) begin
          m_we = 1;
          m_addr = BASE + 32'(4 * (d / 4));
          m_wdata = m_word;
          m_word = 0;
          if (d == 4 * m_len - 1 && !CSUM) begin
            m_busy = 0; m_done = 1;
          end
        end
      end else begin
        m_busy = 0;
        if (in_data == m_x) m_done = 1;
        else m_err = 1;
      end
      m_pos++;
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("mem_we", mem_we, m_we);
      if (mem_we) begin
        log_a.push_back(mem_addr);
        log_d.push_back(mem_wdata);
      end
      if (m_we) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("cpu_hold", cpu_hold, m_busy);
      chk("in_ready", in_ready, m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap,
                           input bit noise);
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    start = noise && ($urandom_range(0, 7) == 0);
    tick();
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic send_frame(input bq_t f,
                            input int gap);
    foreach (f[i]) send_byte(f[i], gap, 1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clr_log();
    log_a.delete();
    log_d.delete();
  endtask

  task automatic check_basic_log(input string tag);
    chk({tag, "_nwr"}, 32'(log_a.size()), 32'd2);
    if (log_a.size() == 2) begin
      chk({tag, "_a0"}, log_a[0], 32'h0);
      chk({tag, "_d0"}, log_d[0], 32'h00100513);
      chk({tag, "_a1"}, log_a[1], 32'h4);
      chk({tag, "_d1"}, log_d[1], 32'h00200593);
    end
  endtask

  bq_t basic;
  bq_t f;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    basic = {8'h02, 8'h00, 8'h13, 8'h05, 8'h10,
             8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    @(negedge clk);
    tick();
    chk_on = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_hold", cpu_hold, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);

    clr_log();
    pulse_start();
    chk("start_hold", cpu_hold, 1'b1);
    send_frame(basic, 0);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'hB0, 0, 1'b0);
`endif
    chk("basic_done", done, 1'b1);
    chk("basic_hold", cpu_hold, 1'b0);
    tick();
    check_basic_log("basic");

    clr_log();
    pulse_start();
    send_frame(basic, 3);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'hB0, 3, 1'b0);
`endif
    tick();
    check_basic_log("gap");
    chk("gap_done", done, 1'b1);

    clr_log();
    pulse_start();
    f = {8'h00, 8'h00};
    send_frame(f, 0);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'h00, 0, 1'b0);
`endif
    chk("zero_done", done, 1'b1);
    tick();
    chk("zero_nwr", 32'(log_a.size()), 32'd0);

    pulse_start();
    f = {8'h01, 8'h01, 8'h13, 8'h05};
    send_frame(f, 0);
    chk("over_err", err, 1'b1);
    chk("over_ready", in_ready, 1'b0);
    chk("over_done", done, 1'b0);
    chk("over_nwr", 32'(log_a.size()), 32'd0);
    pulse_start();
    send_frame(basic, 0);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'hB0, 0, 1'b0);
`endif
    chk("recov_done", done, 1'b1);
    tick();
    check_basic_log("recov");

    clr_log();
    pulse_start();
    for (int i = 0; i < 6; i++)
      send_byte(basic[i], 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_we", mem_we, 1'b0);
    chk("mrst_addr", mem_addr, BASE);
    chk("mrst_wdata", mem_wdata, 32'h0);
    chk("mrst_hold", cpu_hold, 1'b0);
    chk("mrst_ready", in_ready, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_err", err, 1'b0);
    tick();
    chk("mrst_nwr", 32'(log_a.size()), 32'd1);

`ifdef IMEM_LOADER_CSUM_EN
    pulse_start();
    send_frame(basic, 0);
    send_byte(8'h00, 0, 1'b0);
    chk("csum_bad_err", err, 1'b1);
    chk("csum_bad_done", done, 1'b0);
`endif

    for (int it = 0; it < 60; it++) begin
      int n, r, ab, gmax;
      logic [7:0] x;
      r = $urandom_range(0, 9);
      if (r == 0) n = 257 + $urandom_range(0, 300);
      else if (r == 1) n = 0;
      else n = $urandom_range(1, 8);
      gmax = $urandom_range(0, 2);
      f = {};
      f.push_back(8'(n));
      f.push_back(8'(n >> 8));
      x = 8'h00;
      for (int k = 0; k < 4 * ((n > DEPTH) ? 1 : n); k++) begin
        f.push_back(8'($urandom));
        x = x ^ f[f.size() - 1];
      end
      if (CSUM)
        f.push_back(($urandom_range(0, 3) == 0) ?
                    8'(x ^ 8'h5A) : x);
      ab = ($urandom_range(0, 7) == 0) ?
           $urandom_range(0, f.size() - 1) : -1;
      if ($urandom_range(0, 1) == 0) tick();
      pulse_start();
      foreach (f[k]) begin
        if (k == ab) break;
        send_byte(f[k], $urandom_range(0, gmax), 1'b1);
      end
      if (ab >= 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
